powlib_sfifo: RTL and testbench
===============================

Name: powlib_sfifo

Overview:
Single-clock FIFO controller that sequences one powlib_dpram instance as circular storage.
- Write side and read side each use a valid/ready handshake.
- Controller owns the write/read indices and occupancy count. It drives dpram wridx/wrvld/rdidx.
- General-purpose elastic buffer between pipeline stages built from powlib_pipe/powlib_flipflop.

Parameters:
W, 16, data width in bits.
D, 8, depth in words; any value >= 2, not required to be a power of two.
WIDX, powlib_clogb2(D), width of the RAM index.
WCNT, powlib_clogb2(D+1), width of the occupancy count.
AFT, 1, almost-full slack; used only with the optional feature.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
wrdata  input  W  write data
wrvld  input  1  write data valid
wrrdy  output  1  FIFO can accept a write
rddata  output  W  head-of-FIFO data
rdvld  output  1  rddata is valid
rdrdy  input  1  consumer accepts rddata
cnt  output  WCNT  current occupancy, 0..D
wrafull  output  1  almost full (optional feature; tied 0 when disabled)

Behaviour:
- Only clock is clk. rst is sampled on the rising edge of clk. Reset is synchronous and active-high.
- Internal state: wrptr[WIDX], rdptr[WIDX], cnt[WCNT], all registered.
- Reset values:
  - wrptr=0, rdptr=0, cnt=0.
  - Outputs after reset: rdvld=0, wrrdy=1, wrafull=0.
  - RAM contents are not cleared.
- Flags are decoded from cnt only:
  - wrrdy = (cnt != D).
  - rdvld = (cnt != 0).
  - No combinational path from wrvld or rdrdy to wrrdy, rdvld or wrafull.
- Handshakes:
  - Write accepted (wr_x) when wrvld && wrrdy. Read accepted (rd_x) when rdvld && rdrdy.
  - Producer may hold wrvld high while wrrdy=0; wrdata must then be held stable.
  - rdvld, once high, stays high until rd_x.
- Datapath:
  - dpram wridx=wrptr, wrdata=wrdata, wrvld=wr_x, EWBE=0.
  - dpram rdidx=rdptr; rddata comes combinationally from the dpram read port.
- Pointer update:
  - On wr_x, wrptr advances by 1. On rd_x, rdptr advances by 1.
  - Each pointer wraps from D-1 to 0 explicitly, never by natural overflow.
- Count update:
  - wr_x only: cnt+1.
  - rd_x only: cnt-1.
  - Both or neither: unchanged.
- Latency: a word accepted at edge k is on rddata with rdvld=1 in the cycle after edge k. There is no same-cycle bypass.
- Full (cnt==D):
  - wrrdy=0, so no write is accepted even if a read occurs in the same cycle.
  - wrrdy returns to 1 the cycle after the read.
- Empty (cnt==0):
  - rdvld=0. rddata is stale RAM content and must not be checked.
  - A write in this cycle does not make rdvld=1 until the next cycle.
- Simultaneous read and write with 0<cnt<D: both accepted, cnt unchanged, both pointers advance.
- Ordering: strict FIFO; words are read out in acceptance order, including across pointer wrap.
- Reset mid-operation:
  - rst=1 overrides any handshake in the same cycle. Nothing is written to the RAM.
  - State returns to reset values at the next edge, and contents are logically discarded.

Optional Feature:
Macro: POWLIB_SFIFO_AFULL_EN
- Defined:
  - wrafull is a registered flag, equal to (cnt >= D-AFT) evaluated on the next-state count.
  - It therefore changes in the same cycle as cnt.
  - AFT must satisfy 0 <= AFT < D; AFT=0 makes wrafull equivalent to ~wrrdy.
- Not defined:
  - wrafull is tied 0 and no comparator or register is instantiated.
  - The port remains present.

Test Plan:
- Fill (D=8, W=16): after rst, drive 8 writes 0x0001..0x0008 with rdrdy=0 -> wrrdy=0 and cnt=8 after the 8th edge; a 9th write with wrvld=1 is not accepted and cnt stays 8.
- Drain: from full, set rdrdy=1 -> rddata = 0x0001..0x0008 on consecutive cycles, rdvld=0 and cnt=0 after the 8th read, wrrdy=1 the cycle after the first read.
- Wrap / non-power-of-two (D=5): stream 12 words 0x00A0..0x00AB with wrvld=rdrdy=1 continuously -> output order matches, pointers pass 4->0, cnt stays 1 in steady state.
- Simultaneous at boundaries:
  - At cnt=8, wrvld=rdrdy=1 -> only the read is accepted, cnt=7.
  - At cnt=0, wrvld=rdrdy=1 -> only the write is accepted, cnt=1, rdvld=1 next cycle.
- Reset mid-stream: after 3 writes, assert rst for 1 cycle together with wrvld=1 -> cnt=0, rdvld=0, wrrdy=1; next write 0x1234 is the first word read back.
- Almost full (POWLIB_SFIFO_AFULL_EN, D=8, AFT=2): wrafull=0 at cnt=5, rises in the cycle cnt becomes 6, falls when a read takes cnt from 6 to 5; without the macro, wrafull stays 0 throughout.

Source files
------------

// File: rtl/powlib_sfifo.sv
// powlib_sfifo: single-clock valid/ready FIFO over a circular dual-port RAM, any depth >= 2.
// Define POWLIB_SFIFO_AFULL_EN to enable the registered almost-full flag wrafull.
module powlib_sfifo #(
    parameter int W    = 16,
    parameter int D    = 8,
    parameter int WIDX = $clog2(D),
    parameter int WCNT = $clog2(D + 1),
    parameter int AFT  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    wrdata,
    input  logic            wrvld,
    output logic            wrrdy,
    output logic [W-1:0]    rddata,
    output logic            rdvld,
    input  logic            rdrdy,
    output logic [WCNT-1:0] cnt,
    output logic            wrafull
);
    logic [WIDX-1:0] wrptr_q, wrptr_d, rdptr_q, rdptr_d;
    logic [WCNT-1:0] cnt_q, cnt_d;
    logic            wr_x, rd_x;
    logic [W-1:0]    mem_q [D];

    if (D < 2 || AFT < 0 || AFT >= D) begin : g_param_chk
        $error("powlib_sfifo: need D >= 2 and 0 <= AFT < D");
    end

    assign wrrdy  = cnt_q != WCNT'(D);
    assign rdvld  = cnt_q != '0;
    assign wr_x   = wrvld && wrrdy;
    assign rd_x   = rdvld && rdrdy;
    assign cnt    = cnt_q;
    assign rddata = mem_q[rdptr_q];

    // Pointers wrap explicitly so depths that are not a power of two work.
    always_comb begin
        wrptr_d = wr_x ? (wrptr_q == WIDX'(D - 1) ? '0 : wrptr_q + WIDX'(1)) : wrptr_q;
        rdptr_d = rd_x ? (rdptr_q == WIDX'(D - 1) ? '0 : rdptr_q + WIDX'(1)) : rdptr_q;
        cnt_d   = (wr_x && !rd_x) ? cnt_q + WCNT'(1) :
                  (rd_x && !wr_x) ? cnt_q - WCNT'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            cnt_q   <= '0;
        end else begin
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is never cleared; reset only suppresses the write.
    always_ff @(posedge clk) begin
        if (wr_x && !rst) mem_q[wrptr_q] <= wrdata;
    end

`ifdef POWLIB_SFIFO_AFULL_EN
    logic wrafull_q;
    always_ff @(posedge clk) begin
        wrafull_q <= rst ? 1'b0 : (cnt_d >= WCNT'(D - AFT));
    end
    assign wrafull = wrafull_q;
`else
    assign wrafull = 1'b0;
`endif
endmodule

// File: tb/tb_powlib_sfifo.sv
// tb_powlib_sfifo: scoreboard bench for powlib_sfifo at D=8 (AFT=2) and D=5 (wrap).
module tb_powlib_sfifo;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] wrdata, rddata;
    logic        wrvld, wrrdy, rdvld, rdrdy, wrafull;
    logic [3:0]  cnt;
    logic [15:0] b_wrdata, b_rddata;
    logic        b_wrvld, b_wrrdy, b_rdvld, b_rdrdy, b_wrafull;
    logic [2:0]  b_cnt;
    int          n_chk = 0;
    int          n_fail = 0;
    int          mcnt = 0;
    logic [15:0] q[$];
    logic [15:0] qb[$];

    always #5 clk = ~clk;

    powlib_sfifo #(.W(16), .D(8), .AFT(2)) u_a (
        .clk(clk), .rst(rst), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
        .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy), .cnt(cnt), .wrafull(wrafull)
    );

    powlib_sfifo #(.W(16), .D(5), .AFT(1)) u_b (
        .clk(clk), .rst(rst), .wrdata(b_wrdata), .wrvld(b_wrvld), .wrrdy(b_wrrdy),
        .rddata(b_rddata), .rdvld(b_rdvld), .rdrdy(b_rdrdy), .cnt(b_cnt), .wrafull(b_wrafull)
    );

    function automatic logic exp_afull(input int c);
`ifdef POWLIB_SFIFO_AFULL_EN
        return c >= 6;
`else
        return 1'b0;
`endif
    endfunction

    // One cycle on the D=8 instance: flags checked against the model, reads popped from the scoreboard.
    task automatic step(input logic wv, input logic [15:0] wd, input logic rr);
        logic wr_ok, rd_ok;
        logic [15:0] exp;
        wrvld = wv; wrdata = wd; rdrdy = rr;
        @(negedge clk);
        n_chk++;
        if (cnt !== 4'(mcnt) || wrrdy !== (mcnt != 8) || rdvld !== (mcnt != 0) || wrafull !== exp_afull(mcnt)) begin
            n_fail++;
            $display("FAIL step_flags: cnt=%0d wrrdy=%b rdvld=%b wrafull=%b expected cnt=%0d wrrdy=%b rdvld=%b wrafull=%b",
                     cnt, wrrdy, rdvld, wrafull, mcnt, mcnt != 8, mcnt != 0, exp_afull(mcnt));
        end
        wr_ok = wv && mcnt != 8;
        rd_ok = rr && mcnt != 0;
        if (rd_ok) begin
            exp = q.pop_front();
            n_chk++;
            if (rddata !== exp) begin
                n_fail++;
                $display("FAIL rddata: got %h expected %h", rddata, exp);
            end
        end
        if (wr_ok) q.push_back(wd);
        mcnt = mcnt + int'(wr_ok) - int'(rd_ok);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; wrvld = 1'b0; rdrdy = 1'b0; wrdata = '0;
        b_wrvld = 1'b0; b_rdrdy = 1'b0; b_wrdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_chk++;
        if (cnt !== 4'd0 || rdvld !== 1'b0 || wrrdy !== 1'b1 || wrafull !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: cnt=%0d rdvld=%b wrrdy=%b wrafull=%b expected 0 0 1 0", cnt, rdvld, wrrdy, wrafull);
        end
        n_chk++;
        if (b_cnt !== 3'd0 || b_rdvld !== 1'b0 || b_wrrdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_b: cnt=%0d rdvld=%b wrrdy=%b expected 0 0 1", b_cnt, b_rdvld, b_wrrdy);
        end
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0);
        n_chk++;
        if (cnt !== 4'd8 || wrrdy !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: cnt=%0d wrrdy=%b expected 8 0", cnt, wrrdy);
        end
        step(1'b1, 16'h0009, 1'b0);
        n_chk++;
        if (cnt !== 4'd8) begin
            n_fail++;
            $display("FAIL fill_overflow: cnt=%0d expected 8", cnt);
        end
    endtask

    task automatic test_drain;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h0, 1'b1);
            if (i == 0) begin
                n_chk++;
                if (wrrdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL drain_wrrdy: got %b expected 1", wrrdy);
                end
            end
        end
        n_chk++;
        if (cnt !== 4'd0 || rdvld !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: cnt=%0d rdvld=%b expected 0 0", cnt, rdvld);
        end
    endtask

    task automatic test_simul_bounds;
        step(1'b1, 16'h0055, 1'b1);
        n_chk++;
        if (cnt !== 4'd1 || rdvld !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_empty: cnt=%0d rdvld=%b expected 1 1", cnt, rdvld);
        end
        for (int i = 0; i < 7; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
        step(1'b1, 16'hBEEF, 1'b1);
        n_chk++;
        if (cnt !== 4'd7 || wrrdy !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_full: cnt=%0d wrrdy=%b expected 7 1", cnt, wrrdy);
        end
        step(1'b1, 16'h0200, 1'b1);
        while (mcnt != 0) step(1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_afull;
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0300 + 16'(i), 1'b0);
        n_chk++;
        if (cnt !== 4'd5 || wrafull !== 1'b0) begin
            n_fail++;
            $display("FAIL afull_at5: cnt=%0d wrafull=%b expected 5 0", cnt, wrafull);
        end
        step(1'b1, 16'h0305, 1'b0);
        n_chk++;
        if (cnt !== 4'd6 || wrafull !== exp_afull(6)) begin
            n_fail++;
            $display("FAIL afull_rise: cnt=%0d wrafull=%b expected 6 %b", cnt, wrafull, exp_afull(6));
        end
        step(1'b0, 16'h0, 1'b1);
        n_chk++;
        if (cnt !== 4'd5 || wrafull !== 1'b0) begin
            n_fail++;
            $display("FAIL afull_fall: cnt=%0d wrafull=%b expected 5 0", cnt, wrafull);
        end
        while (mcnt != 0) step(1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0400 + 16'(i), 1'b0);
        rst = 1'b1; wrvld = 1'b1; wrdata = 16'hDEAD; rdrdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mcnt = 0;
        q.delete();
        n_chk++;
        if (cnt !== 4'd0 || rdvld !== 1'b0 || wrrdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: cnt=%0d rdvld=%b wrrdy=%b expected 0 0 1", cnt, rdvld, wrrdy);
        end
        step(1'b1, 16'h1234, 1'b0);
        step(1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_wrap;
        logic [15:0] exp;
        for (int i = 0; i <= 12; i++) begin
            b_wrvld = i < 12; b_wrdata = 16'h00A0 + 16'(i); b_rdrdy = 1'b1;
            @(negedge clk);
            if (i > 0) begin
                exp = qb.pop_front();
                n_chk++;
                if (b_cnt !== 3'd1 || b_rdvld !== 1'b1 || b_rddata !== exp) begin
                    n_fail++;
                    $display("FAIL wrap_%0d: cnt=%0d rdvld=%b rddata=%h expected 1 1 %h", i, b_cnt, b_rdvld, b_rddata, exp);
                end
            end
            if (i < 12) qb.push_back(b_wrdata);
            @(posedge clk); #1;
        end
        b_wrvld = 1'b0; b_rdrdy = 1'b0;
        n_chk++;
        if (b_cnt !== 3'd0 || b_rdvld !== 1'b0 || b_wrrdy !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_end: cnt=%0d rdvld=%b wrrdy=%b expected 0 0 1", b_cnt, b_rdvld, b_wrrdy);
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_drain;
        test_simul_bounds;
        test_afull;
        test_reset_mid;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
